// File: rtl/cr_osf_support_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cr_osf_support_mc_pkg
// Description : Shared types for the multi-channel OSF support monitor:
//               TLV type codes, parser state enums and the byte-count width
//               helper.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
package cr_osf_support_mc_pkg;

  // TLV type codes seen in the tlv_type field of a header (SOF) beat
  localparam logic [7:0] TLV_RQE      = 8'h01;
  localparam logic [7:0] TLV_CQE      = 8'h0A;
  localparam logic [7:0] TLV_DATA     = 8'h0C;
  localparam logic [7:0] TLV_DATA_UNK = 8'h0D;

  // Command window parser
  typedef enum logic [1:0] {
    OSF_MC_CMD_IDLE = 2'd0,
    OSF_MC_CMD_RQE  = 2'd1,
    OSF_MC_CMD_CQE  = 2'd2
  } osf_mc_cmd_e;

  // Data frame parser
  typedef enum logic [0:0] {
    OSF_MC_DATA_IDLE = 1'b0,
    OSF_MC_DATA_DATA = 1'b1
  } osf_mc_data_e;

  // Width needed to hold a byte count of 0..data_bytes
  function automatic int amt_w(input int data_bytes);
    return $clog2(data_bytes + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cr_osf_support_ch.sv
`default_nettype none
// ============================================================================
// Module      : cr_osf_support_ch
// Description : Single-channel OSF snoop: stall/backpressure event registers,
//               command-window parser and data-frame length parser.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module cr_osf_support_ch
  import cr_osf_support_mc_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int LEN_W      = 16,
  parameter int AMT_W      = amt_w(DATA_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ib_tvalid,
  input  logic                  ib_tready,
  input  logic                  cg_tvalid,
  input  logic                  cg_tready,
  input  logic                  ob_rd,
  input  logic                  ob_fifo_empty,
  input  logic                  ob_sof,
  input  logic                  ob_eof,
  input  logic [7:0]            ob_tlv_type,
  input  logic [DATA_BYTES-1:0] ob_tstrb,
  output logic                  dat_fifo_stall,
  output logic                  pdt_fifo_stall,
  output logic                  ob_stall,
  output logic                  ob_sys_bp,
  output logic                  cqe_exit,
  output logic                  cmd_active,
  output logic                  frame_cnt_stb,
  output logic                  bytes_cnt_stb,
  output logic [AMT_W-1:0]      bytes_cnt_amt,
  output logic                  frame_len_stb,
  output logic [LEN_W-1:0]      frame_len,
  output logic                  proto_err
);

  osf_mc_cmd_e         cmd_q, cmd_d;
  osf_mc_data_e        data_q, data_d;
  logic                cqe_exit_d;
  logic [LEN_W-1:0]    acc_q, acc_d;
  logic                frame_cnt_d, bytes_stb_d, len_stb_d, err_d;
  logic [AMT_W-1:0]    amt, amt_d;
  logic [LEN_W-1:0]    len_d;
  logic [LEN_W:0]      sum;
  logic [LEN_W-1:0]    sum_sat;
  logic                is_data_type;

  // Beat byte count and saturating accumulation (extra MSB catches overflow)
  always_comb begin
    amt          = AMT_W'($countones(ob_tstrb));
    sum          = {1'b0, acc_q} + (LEN_W+1)'(amt);
    sum_sat      = sum[LEN_W] ? {LEN_W{1'b1}} : sum[LEN_W-1:0];
    is_data_type = (ob_tlv_type == TLV_DATA) || (ob_tlv_type == TLV_DATA_UNK);
  end

  // Command window: RQE opens it, the EOF of a CQE closes it and pulses exit.
  // A CQE is honoured even without a preceding RQE.
  always_comb begin
    cmd_d      = cmd_q;
    cqe_exit_d = 1'b0;
    if (ob_rd) begin
      case (cmd_q)
        OSF_MC_CMD_CQE: begin
          if (ob_eof) begin
            cmd_d      = OSF_MC_CMD_IDLE;
            cqe_exit_d = 1'b1;
          end
        end
        default: begin
          if (ob_sof && (ob_tlv_type == TLV_CQE)) begin
            if (ob_eof) begin
              cmd_d      = OSF_MC_CMD_IDLE;
              cqe_exit_d = 1'b1;
            end else begin
              cmd_d = OSF_MC_CMD_CQE;
            end
          end else if (ob_sof && (ob_tlv_type == TLV_RQE)) begin
            cmd_d = OSF_MC_CMD_RQE;
          end
        end
      endcase
    end
  end

  // Data frame parser: header beat is not counted, later beats accumulate.
  // A SOF always restarts parsing; SOF inside an open frame or a stray EOF
  // flags a protocol error.
  always_comb begin
    data_d      = data_q;
    acc_d       = acc_q;
    frame_cnt_d = 1'b0;
    bytes_stb_d = 1'b0;
    amt_d       = '0;
    len_stb_d   = 1'b0;
    len_d       = frame_len;
    err_d       = 1'b0;
    if (ob_rd) begin
      if (ob_sof) begin
        err_d  = (data_q == OSF_MC_DATA_DATA);
        acc_d  = '0;
        data_d = OSF_MC_DATA_IDLE;
        if (is_data_type) begin
          frame_cnt_d = 1'b1;
          if (ob_eof) begin
            len_stb_d = 1'b1;
            len_d     = '0;
          end else begin
            data_d = OSF_MC_DATA_DATA;
          end
        end
      end else if (data_q == OSF_MC_DATA_DATA) begin
        bytes_stb_d = 1'b1;
        amt_d       = amt;
        if (ob_eof) begin
          len_stb_d = 1'b1;
          len_d     = sum_sat;
          acc_d     = '0;
          data_d    = OSF_MC_DATA_IDLE;
        end else begin
          acc_d = sum_sat;
        end
      end else if (ob_eof) begin
        err_d = 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q          <= OSF_MC_CMD_IDLE;
      data_q         <= OSF_MC_DATA_IDLE;
      acc_q          <= '0;
      dat_fifo_stall <= 1'b0;
      pdt_fifo_stall <= 1'b0;
      ob_stall       <= 1'b0;
      ob_sys_bp      <= 1'b0;
      cqe_exit       <= 1'b0;
      frame_cnt_stb  <= 1'b0;
      bytes_cnt_stb  <= 1'b0;
      bytes_cnt_amt  <= '0;
      frame_len_stb  <= 1'b0;
      frame_len      <= '0;
      proto_err      <= 1'b0;
    end else begin
      cmd_q          <= cmd_d;
      data_q         <= data_d;
      acc_q          <= acc_d;
      dat_fifo_stall <= ib_tvalid & ~ib_tready;
      pdt_fifo_stall <= cg_tvalid & ~cg_tready;
      ob_stall       <= ob_fifo_empty & cmd_active;
      ob_sys_bp      <= ~ob_fifo_empty & ~ob_rd;
      cqe_exit       <= cqe_exit_d;
      frame_cnt_stb  <= frame_cnt_d;
      bytes_cnt_stb  <= bytes_stb_d;
      bytes_cnt_amt  <= amt_d;
      frame_len_stb  <= len_stb_d;
      frame_len      <= len_d;
      proto_err      <= err_d;
    end
  end

  assign cmd_active = (cmd_q != OSF_MC_CMD_IDLE);

endmodule
`default_nettype wire

// File: rtl/cr_osf_support_mc.sv
`default_nettype none
// ============================================================================
// Module      : cr_osf_support_mc
// Description : Multi-channel passive OSF support/statistics monitor; one
//               independent channel parser per outbound stream.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module cr_osf_support_mc
  import cr_osf_support_mc_pkg::*;
#(
  parameter  int NUM_CH     = 2,
  parameter  int DATA_BYTES = 8,
  parameter  int LEN_W      = 16,
  localparam int AMT_W      = amt_w(DATA_BYTES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ib_tvalid,
  input  logic [NUM_CH-1:0]            ib_tready,
  input  logic [NUM_CH-1:0]            cg_tvalid,
  input  logic [NUM_CH-1:0]            cg_tready,
  input  logic [NUM_CH-1:0]            ob_rd,
  input  logic [NUM_CH-1:0]            ob_fifo_empty,
  input  logic [NUM_CH-1:0]            ob_sof,
  input  logic [NUM_CH-1:0]            ob_eof,
  input  logic [8*NUM_CH-1:0]          ob_tlv_type,
  input  logic [DATA_BYTES*NUM_CH-1:0] ob_tstrb,
  output logic [NUM_CH-1:0]            dat_fifo_stall,
  output logic [NUM_CH-1:0]            pdt_fifo_stall,
  output logic [NUM_CH-1:0]            ob_stall,
  output logic [NUM_CH-1:0]            ob_sys_bp,
  output logic [NUM_CH-1:0]            cqe_exit,
  output logic [NUM_CH-1:0]            cmd_active,
  output logic [NUM_CH-1:0]            frame_cnt_stb,
  output logic [NUM_CH-1:0]            bytes_cnt_stb,
  output logic [AMT_W*NUM_CH-1:0]      bytes_cnt_amt,
  output logic [NUM_CH-1:0]            frame_len_stb,
  output logic [LEN_W*NUM_CH-1:0]      frame_len,
  output logic [NUM_CH-1:0]            proto_err
);

  // One parser per channel on its slice of the flat vectors
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    cr_osf_support_ch #(
      .DATA_BYTES (DATA_BYTES),
      .LEN_W      (LEN_W),
      .AMT_W      (AMT_W)
    ) u_ch (
      .clk            (clk),
      .rst_n          (rst_n),
      .ib_tvalid      (ib_tvalid[c]),
      .ib_tready      (ib_tready[c]),
      .cg_tvalid      (cg_tvalid[c]),
      .cg_tready      (cg_tready[c]),
      .ob_rd          (ob_rd[c]),
      .ob_fifo_empty  (ob_fifo_empty[c]),
      .ob_sof         (ob_sof[c]),
      .ob_eof         (ob_eof[c]),
      .ob_tlv_type    (ob_tlv_type[8*c +: 8]),
      .ob_tstrb       (ob_tstrb[DATA_BYTES*c +: DATA_BYTES]),
      .dat_fifo_stall (dat_fifo_stall[c]),
      .pdt_fifo_stall (pdt_fifo_stall[c]),
      .ob_stall       (ob_stall[c]),
      .ob_sys_bp      (ob_sys_bp[c]),
      .cqe_exit       (cqe_exit[c]),
      .cmd_active     (cmd_active[c]),
      .frame_cnt_stb  (frame_cnt_stb[c]),
      .bytes_cnt_stb  (bytes_cnt_stb[c]),
      .bytes_cnt_amt  (bytes_cnt_amt[AMT_W*c +: AMT_W]),
      .frame_len_stb  (frame_len_stb[c]),
      .frame_len      (frame_len[LEN_W*c +: LEN_W]),
      .proto_err      (proto_err[c])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_cr_osf_support_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_cr_osf_support_mc
// Description : Self-checking bench for cr_osf_support_mc: directed frames
//               plus randomized traffic against a frame-level reference model,
//               and a narrow-accumulator instance for length saturation.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module tb_cr_osf_support_mc;
  import cr_osf_support_mc_pkg::*;

  localparam int NCH   = 2;
  localparam int DB    = 8;
  localparam int LW    = 16;
  localparam int AW    = $clog2(DB + 1);
  localparam int SLW   = 4;
  localparam int LMAX  = (1 << LW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic [NCH-1:0]    ib_tvalid, ib_tready, cg_tvalid, cg_tready;
  logic [NCH-1:0]    ob_rd, ob_fifo_empty, ob_sof, ob_eof;
  logic [8*NCH-1:0]  ob_tlv_type;
  logic [DB*NCH-1:0] ob_tstrb;
  logic [NCH-1:0]    dat_fifo_stall, pdt_fifo_stall, ob_stall, ob_sys_bp;
  logic [NCH-1:0]    cqe_exit, cmd_active, frame_cnt_stb, bytes_cnt_stb;
  logic [AW*NCH-1:0] bytes_cnt_amt;
  logic [NCH-1:0]    frame_len_stb, proto_err;
  logic [LW*NCH-1:0] frame_len;

  cr_osf_support_mc #(.NUM_CH(NCH), .DATA_BYTES(DB), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ib_tvalid(ib_tvalid), .ib_tready(ib_tready),
    .cg_tvalid(cg_tvalid), .cg_tready(cg_tready),
    .ob_rd(ob_rd), .ob_fifo_empty(ob_fifo_empty),
    .ob_sof(ob_sof), .ob_eof(ob_eof),
    .ob_tlv_type(ob_tlv_type), .ob_tstrb(ob_tstrb),
    .dat_fifo_stall(dat_fifo_stall), .pdt_fifo_stall(pdt_fifo_stall),
    .ob_stall(ob_stall), .ob_sys_bp(ob_sys_bp),
    .cqe_exit(cqe_exit), .cmd_active(cmd_active),
    .frame_cnt_stb(frame_cnt_stb), .bytes_cnt_stb(bytes_cnt_stb),
    .bytes_cnt_amt(bytes_cnt_amt), .frame_len_stb(frame_len_stb),
    .frame_len(frame_len), .proto_err(proto_err)
  );

  // Narrow-accumulator instance
  logic           s_rd, s_sof, s_eof;
  logic [7:0]     s_type;
  logic [DB-1:0]  s_strb;
  logic           s_dat, s_pdt, s_stall, s_bp, s_cqe, s_act, s_fcs, s_bcs;
  logic [AW-1:0]  s_amt;
  logic           s_lstb, s_err;
  logic [SLW-1:0] s_len;

  cr_osf_support_mc #(.NUM_CH(1), .DATA_BYTES(DB), .LEN_W(SLW)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .ib_tvalid(1'b0), .ib_tready(1'b0), .cg_tvalid(1'b0), .cg_tready(1'b0),
    .ob_rd(s_rd), .ob_fifo_empty(1'b0), .ob_sof(s_sof), .ob_eof(s_eof),
    .ob_tlv_type(s_type), .ob_tstrb(s_strb),
    .dat_fifo_stall(s_dat), .pdt_fifo_stall(s_pdt),
    .ob_stall(s_stall), .ob_sys_bp(s_bp),
    .cqe_exit(s_cqe), .cmd_active(s_act),
    .frame_cnt_stb(s_fcs), .bytes_cnt_stb(s_bcs),
    .bytes_cnt_amt(s_amt), .frame_len_stb(s_lstb),
    .frame_len(s_len), .proto_err(s_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: per-channel view of "inside a command window",
  // "waiting for the CQE end", "frame open" and the running byte total.
  bit m_win   [NCH];
  bit m_incqe [NCH];
  bit m_frame [NCH];
  int m_acc   [NCH];
  int m_len   [NCH];

  logic [NCH-1:0]    e_dat, e_pdt, e_stall, e_bp, e_cqe, e_act, e_fcs, e_bcs, e_lstb, e_err;
  logic [AW*NCH-1:0] e_amt;
  logic [LW*NCH-1:0] e_len;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_win[c] = 0; m_incqe[c] = 0; m_frame[c] = 0; m_acc[c] = 0; m_len[c] = 0;
    end
    e_dat = '0; e_pdt = '0; e_stall = '0; e_bp = '0; e_cqe = '0; e_act = '0;
    e_fcs = '0; e_bcs = '0; e_lstb = '0; e_err = '0; e_amt = '0; e_len = '0;
  endtask

  // Consume this cycle's inputs; produce what the outputs must show next cycle
  task automatic model_eval();
    for (int c = 0; c < NCH; c++) begin
      bit   rd, sof, eof, is_data;
      logic [7:0] t;
      int   amt;
      rd  = ob_rd[c];
      sof = ob_sof[c];
      eof = ob_eof[c];
      t   = ob_tlv_type[8*c +: 8];
      amt = $countones(ob_tstrb[DB*c +: DB]);
      is_data = (t == TLV_DATA) || (t == TLV_DATA_UNK);

      e_dat[c]   = ib_tvalid[c] & ~ib_tready[c];
      e_pdt[c]   = cg_tvalid[c] & ~cg_tready[c];
      e_stall[c] = ob_fifo_empty[c] & m_win[c];
      e_bp[c]    = ~ob_fifo_empty[c] & ~ob_rd[c];

      e_cqe[c] = 1'b0;
      if (rd) begin
        if (m_incqe[c]) begin
          if (eof) begin e_cqe[c] = 1'b1; m_win[c] = 0; m_incqe[c] = 0; end
        end else if (sof && t == TLV_CQE) begin
          if (eof) begin e_cqe[c] = 1'b1; m_win[c] = 0; end
          else begin m_win[c] = 1; m_incqe[c] = 1; end
        end else if (sof && t == TLV_RQE) begin
          m_win[c] = 1;
        end
      end
      e_act[c] = m_win[c];

      e_fcs[c] = 1'b0; e_bcs[c] = 1'b0; e_lstb[c] = 1'b0; e_err[c] = 1'b0;
      e_amt[AW*c +: AW] = '0;
      if (rd) begin
        if (sof) begin
          e_err[c]   = m_frame[c];
          m_frame[c] = 0;
          m_acc[c]   = 0;
          if (is_data) begin
            e_fcs[c] = 1'b1;
            if (eof) begin e_lstb[c] = 1'b1; m_len[c] = 0; end
            else m_frame[c] = 1;
          end
        end else if (m_frame[c]) begin
          e_bcs[c] = 1'b1;
          e_amt[AW*c +: AW] = AW'(amt);
          m_acc[c] = (m_acc[c] + amt > LMAX) ? LMAX : m_acc[c] + amt;
          if (eof) begin
            e_lstb[c]  = 1'b1;
            m_len[c]   = m_acc[c];
            m_acc[c]   = 0;
            m_frame[c] = 0;
          end
        end else if (eof) begin
          e_err[c] = 1'b1;
        end
      end
      e_len[LW*c +: LW] = LW'(m_len[c]);
    end
  endtask

  task automatic compare_all();
    check("dat_fifo_stall", dat_fifo_stall, e_dat);
    check("pdt_fifo_stall", pdt_fifo_stall, e_pdt);
    check("ob_stall",       ob_stall,       e_stall);
    check("ob_sys_bp",      ob_sys_bp,      e_bp);
    check("cqe_exit",       cqe_exit,       e_cqe);
    check("cmd_active",     cmd_active,     e_act);
    check("frame_cnt_stb",  frame_cnt_stb,  e_fcs);
    check("bytes_cnt_stb",  bytes_cnt_stb,  e_bcs);
    check("bytes_cnt_amt",  bytes_cnt_amt,  e_amt);
    check("frame_len_stb",  frame_len_stb,  e_lstb);
    check("frame_len",      frame_len,      e_len);
    check("proto_err",      proto_err,      e_err);
  endtask

  // Called just after a falling edge with inputs already driven
  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ib_tvalid = '0; ib_tready = '0; cg_tvalid = '0; cg_tready = '0;
    ob_rd = '0; ob_fifo_empty = '1; ob_sof = '0; ob_eof = '0;
    ob_tlv_type = '0; ob_tstrb = '0;
    s_rd = 1'b0; s_sof = 1'b0; s_eof = 1'b0; s_type = '0; s_strb = '0;
  endtask

  task automatic beat(input int c, input bit sof, input bit eof,
                      input logic [7:0] t, input logic [DB-1:0] strb);
    ob_rd[c] = 1'b1; ob_fifo_empty[c] = 1'b0;
    ob_sof[c] = sof; ob_eof[c] = eof;
    ob_tlv_type[8*c +: 8] = t;
    ob_tstrb[DB*c +: DB] = strb;
  endtask

  task automatic sat_beat(input bit sof, input bit eof, input logic [7:0] t);
    s_rd = 1'b1; s_sof = sof; s_eof = eof; s_type = t; s_strb = '1;
  endtask

  logic [7:0] types [5];

  task automatic random_inputs();
    for (int c = 0; c < NCH; c++) begin
      ib_tvalid[c]     = 1'($urandom_range(0, 1));
      ib_tready[c]     = 1'($urandom_range(0, 1));
      cg_tvalid[c]     = 1'($urandom_range(0, 1));
      cg_tready[c]     = 1'($urandom_range(0, 1));
      ob_rd[c]         = ($urandom_range(0, 9) < 7);
      ob_fifo_empty[c] = ($urandom_range(0, 3) == 0);
      ob_sof[c]        = ($urandom_range(0, 4) == 0);
      ob_eof[c]        = ($urandom_range(0, 3) == 0);
      ob_tlv_type[8*c +: 8] = types[$urandom_range(0, 4)];
      ob_tstrb[DB*c +: DB]  = ($urandom_range(0, 1) == 1) ? '1 : DB'($urandom);
    end
  endtask

  initial begin
    types[0] = TLV_RQE; types[1] = TLV_CQE; types[2] = TLV_DATA;
    types[3] = TLV_DATA_UNK; types[4] = 8'h55;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("sat_len_rst", s_len, 0);
    rst_n = 1'b1;

    // Ch0 command window; Ch1 data frame 8+8+4; narrow instance 3x8 bytes
    idle_inputs(); beat(0, 1, 0, TLV_RQE, '1); beat(1, 1, 0, TLV_DATA, '1);
    sat_beat(1, 0, TLV_DATA);
    step();
    check("ch0_act_after_rqe", cmd_active[0], 1);
    check("ch1_frame_cnt", frame_cnt_stb[1], 1);
    idle_inputs(); beat(0, 0, 0, 8'h00, '1); beat(1, 0, 0, 8'h00, 8'hFF);
    sat_beat(0, 0, 8'h00);
    step();
    check("ch1_amt_b1", bytes_cnt_amt[AW +: AW], 8);
    idle_inputs(); beat(0, 0, 0, 8'h00, '1); beat(1, 0, 0, 8'h00, 8'hFF);
    sat_beat(0, 0, 8'h00);
    step();
    idle_inputs(); beat(0, 0, 0, 8'h00, '1); beat(1, 0, 1, 8'h00, 8'h0F);
    sat_beat(0, 1, 8'h00);
    step();
    check("ch1_amt_b3", bytes_cnt_amt[AW +: AW], 4);
    check("ch1_len_stb", frame_len_stb[1], 1);
    check("ch1_len", frame_len[LW +: LW], 20);
    check("sat_len_stb", s_lstb, 1);
    check("sat_len", s_len, 15);
    idle_inputs(); beat(0, 1, 0, TLV_CQE, '1);
    step();
    check("ch0_act_in_cqe", cmd_active[0], 1);
    idle_inputs(); beat(0, 0, 1, 8'h00, '1);
    step();
    check("ch0_cqe_exit", cqe_exit[0], 1);
    check("ch0_act_fall", cmd_active[0], 0);
    idle_inputs();
    step();
    check("ch0_cqe_exit_once", cqe_exit[0], 0);

    // SOF inside an open frame
    idle_inputs(); beat(0, 1, 0, TLV_DATA_UNK, '1); step();
    idle_inputs(); beat(0, 0, 0, 8'h00, 8'h3C); step();
    idle_inputs(); beat(0, 1, 0, TLV_DATA, '1); step();
    check("ch0_proto_err", proto_err[0], 1);
    check("ch0_second_frame", frame_cnt_stb[0], 1);
    check("ch0_no_len_stb", frame_len_stb[0], 0);
    idle_inputs(); beat(0, 0, 1, 8'h00, 8'h01); step();
    check("ch0_len_after_restart", frame_len[0 +: LW], 1);

    // Single-beat CQE and single-beat DATA
    idle_inputs(); beat(0, 1, 1, TLV_CQE, '1); beat(1, 1, 1, TLV_DATA, '1); step();
    check("ch0_single_cqe_exit", cqe_exit[0], 1);
    check("ch1_single_len_stb", frame_len_stb[1], 1);
    check("ch1_single_len", frame_len[LW +: LW], 0);

    // Stall and system backpressure
    idle_inputs(); beat(0, 1, 0, TLV_RQE, '1); step();
    idle_inputs(); ob_fifo_empty[0] = 1'b1; step();
    check("ch0_ob_stall", ob_stall[0], 1);
    idle_inputs(); ob_fifo_empty[0] = 1'b0; step();
    check("ch0_sys_bp", ob_sys_bp[0], 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      idle_inputs();
      random_inputs();
      step();
    end

    // Reset in the middle of a frame
    idle_inputs(); beat(1, 1, 0, TLV_DATA, '1); step();
    idle_inputs(); beat(1, 0, 0, 8'h00, '1); step();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk); #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs(); beat(1, 0, 1, 8'h00, '1); step();
    check("ch1_eof_after_rst_err", proto_err[1], 1);
    check("ch1_no_len_after_rst", frame_len_stb[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
